// File: rtl/truth_table_sweep_ctrl.sv
// Sweeps a 3-input logic block through all eight input vectors, samples its response
// after a settle delay and compares the measured truth table against an expected one.
module truth_table_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] table_cfg,
    input  logic       dut_out,
    output logic [2:0] in_bits,
    output logic       busy,
    output logic       done,
    output logic [7:0] captured,
    output logic [7:0] mismatch,
    output logic [3:0] mismatch_cnt,
    output logic       pass
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t           state;
    logic [2:0]       idx;
    logic [CNT_W-1:0] settle_cnt;
    logic [7:0]       exp_tbl;

    // Vector idx lives at bit 7-idx so the table reads MSB-first from vector 000.
    logic [2:0] bit_pos;
    logic       miss_bit;

    assign bit_pos  = 3'd7 - idx;
    assign miss_bit = dut_out ^ exp_tbl[bit_pos];

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; the reset branch covers every register, leaving none
    // to power up undefined.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= 3'd0;
            settle_cnt   <= '0;
            exp_tbl      <= 8'h00;
            in_bits      <= 3'b000;
            busy         <= 1'b0;
            done         <= 1'b0;
            captured     <= 8'h00;
            mismatch     <= 8'h00;
            mismatch_cnt <= 4'd0;
            pass         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        exp_tbl      <= table_cfg;
                        idx          <= 3'd0;
                        in_bits      <= 3'b000;
                        settle_cnt   <= '0;
                        captured     <= 8'h00;
                        mismatch     <= 8'h00;
                        mismatch_cnt <= 4'd0;
                        pass         <= 1'b0;
                        busy         <= 1'b1;
                        state        <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (abort) begin
                        state      <= IDLE;
                        idx        <= 3'd0;
                        settle_cnt <= '0;
                        in_bits    <= 3'b000;
                        busy       <= 1'b0;
                        pass       <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                        if (settle_cnt == CNT_LAST) begin
                            state <= SAMPLE;
                        end
                    end
                end

                SAMPLE: begin
                    if (abort) begin
                        state      <= IDLE;
                        idx        <= 3'd0;
                        settle_cnt <= '0;
                        in_bits    <= 3'b000;
                        busy       <= 1'b0;
                        pass       <= 1'b0;
                    end else begin
                        captured[bit_pos] <= dut_out;
                        mismatch[bit_pos] <= miss_bit;
                        mismatch_cnt      <= mismatch_cnt + {3'b000, miss_bit};
                        settle_cnt        <= '0;
                        if (idx == 3'd7) begin
                            // in_bits stays at 111; pass must include this last compare.
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (mismatch_cnt == 4'd0) && !miss_bit;
                            state <= DONE;
                        end else begin
                            idx     <= idx + 3'd1;
                            in_bits <= idx + 3'd1;
                            state   <= SETTLE;
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
